pe_bfly_array: RTL and testbench
================================

PE_BFLY_ARRAY -- requirements
Module: pe_bfly_array

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel butterfly lanes (1..16).
REQ-002 SHALL have parameter Q, default 3329, modulus, applied uniformly to every lane.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port a_i  in  LANES x coeff_t  per-lane operand A.
REQ-006 SHALL have port b_i  in  LANES x coeff_t  per-lane operand B.
REQ-007 SHALL have port w_i  in  LANES x coeff_t  per-lane CWM/COMP/DECOMP multiplier.
REQ-008 SHALL have port tf_i  in  coeff_t  shared twiddle factor for NTT/INTT.
REQ-009 SHALL have port ctrl_i  in  pe_mode_e  operation mode of the beat.
REQ-010 SHALL have ports in_valid_i (in, 1) and in_ready_o (out, 1), the input handshake.
REQ-011 SHALL have ports u_o and v_o (out, LANES x coeff_t), the per-lane results.
REQ-012 SHALL have ports out_valid_o (out, 1) and out_ready_i (in, 1), the output handshake.
REQ-013 SHALL have port busy_o  out  1  high while any beat is in flight.

Function
REQ-014 A beat SHALL transfer on a clock edge where valid and ready are both high, on either side.
REQ-015 Effective multiplier SHALL be tf_i when ctrl_i[1]=1, otherwise w_i[k].
REQ-016 NTT/CWM: t=b*m mod Q; u=a+t; v=a-t. INTT: u=(a+b)/2 mod Q (odd sums add Q before halving); v=(a-b)*m. ADDSUB: u=a+b; v=a-b. COMP/DECOMP: u=a; v=b*m. All results SHALL lie in [0,Q-1].
REQ-017 Unstalled latency SHALL be PE_ARRAY_LAT=3 cycles from input transfer to out_valid_o, with one beat per cycle throughput.
REQ-018 The pipeline SHALL advance only when the output stage is empty or out_ready_i=1; otherwise every stage SHALL hold, and no beat SHALL be lost or duplicated.
REQ-019 out_valid_o SHALL remain high and u_o/v_o stable until the beat transfers.
REQ-020 in_ready_o SHALL be high in state IDLE, and in state RUN whenever the pipeline advances and ctrl_i equals the latched mode.
REQ-021 The FSM SHALL have three states:
  - IDLE: empty pipe; on in_valid_i, latch mode and go to RUN.
  - RUN: ctrl_i differs from the latched mode while in_valid_i=1 -> DRAIN, with in_ready_o=0; occupancy reaches 0 -> IDLE.
  - DRAIN: in_ready_o=0; occupancy reaches 0 -> IDLE, which then latches the new mode.
REQ-022 An occupancy counter (0..PE_ARRAY_LAT, plus 2 when the skid is present) SHALL increment on input transfer and decrement on output transfer; a simultaneous transfer on both sides SHALL leave it unchanged.
REQ-023 busy_o SHALL equal (occupancy != 0).
REQ-024 Inputs with in_valid_i=0 SHALL never produce out_valid_o.

Reset
REQ-025 rst_n low SHALL immediately clear in_ready_o, out_valid_o, busy_o, occupancy, all stage valids, and u_o/v_o to 0, and set the FSM to IDLE, even mid-operation.
REQ-026 In-flight beats SHALL be discarded on reset.
REQ-027 in_ready_o SHALL be high from the first edge after rst_n deasserts.

Configuration
REQ-028 With PE_ARRAY_SKID_EN defined, a 2-entry output skid buffer SHALL be inserted, so in_ready_o has no combinational path from out_ready_i; latency SHALL be unchanged.
REQ-029 Without PE_ARRAY_SKID_EN, in_ready_o MAY depend combinationally on out_ready_i.

Structure
REQ-030 coeff_t, pe_mode_e and PE_ARRAY_LAT SHALL live in poly_arith_pkg.
REQ-031 One sub-module, pe_lane, SHALL implement a single pipelined lane with a stage-enable input, instantiated LANES times by generate.

Verification
REQ-032 NTT, a=10, b=2, tf=5, w=999, all lanes -> u=20, v=0 exactly 3 cycles later.
REQ-033 INTT, a=1, b=0, tf=1 -> u=1665, v=1; and a=0, b=1, tf=1 -> u=1665, v=3328.
REQ-034 CWM, a=100, b=50, w=4, tf=999 -> u=300, v=3229; and ADDSUB, a=1000, b=2000 -> u=3000, v=2329.
REQ-035 Stream 6 NTT beats with out_ready_i low for 5 cycles -> in_ready_o drops once the pipe is full, and all 6 results emerge in order with none lost.
REQ-036 NTT beat followed immediately by ADDSUB -> in_ready_o=0 (DRAIN) until the NTT result transfers, then ADDSUB is accepted and correct.
REQ-037 Assert rst_n low with 2 beats in flight -> out_valid_o=0 and busy_o=0 immediately, and no ghost outputs after release.

Source files
------------

// File: rtl/poly_arith_pkg.sv
// Shared coefficient/mode types, pipeline depth and modular helpers for the butterfly PE array.
package poly_arith_pkg;

  localparam int unsigned CoeffW       = 12;
  localparam int unsigned PE_ARRAY_LAT = 3;

  typedef logic [CoeffW-1:0] coeff_t;

  // Bit 1 set selects the shared twiddle factor as the multiplier.
  typedef enum logic [2:0] {
    ModeCwm    = 3'd0,
    ModeAddSub = 3'd1,
    ModeNtt    = 3'd2,
    ModeIntt   = 3'd3,
    ModeComp   = 3'd4,
    ModeDecomp = 3'd5
  } pe_mode_e;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} pe_state_e;

  typedef struct packed {
    pe_mode_e mode;
    coeff_t   a;
    coeff_t   b;
    coeff_t   m;
  } pe_s1_t;

  typedef struct packed {
    pe_mode_e mode;
    coeff_t   a;
    coeff_t   b;
    coeff_t   prod;
    coeff_t   half;
  } pe_s2_t;

  function automatic coeff_t add_mod(coeff_t x, coeff_t y, coeff_t q);
    logic [CoeffW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[CoeffW-1:0];
  endfunction

  function automatic coeff_t sub_mod(coeff_t x, coeff_t y, coeff_t q);
    logic [CoeffW:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) d = d + {1'b0, q};
    return d[CoeffW-1:0];
  endfunction

  function automatic coeff_t mul_mod(coeff_t x, coeff_t y, coeff_t q);
    logic [2*CoeffW-1:0] p;
    p = {{CoeffW{1'b0}}, x} * {{CoeffW{1'b0}}, y};
    p = p % {{CoeffW{1'b0}}, q};
    return p[CoeffW-1:0];
  endfunction

  // (x+y)/2 mod q: odd residues borrow one q so the halving is exact.
  function automatic coeff_t half_mod(coeff_t x, coeff_t y, coeff_t q);
    coeff_t          s;
    logic [CoeffW:0] t;
    s = add_mod(x, y, q);
    t = s[0] ? ({1'b0, s} + {1'b0, q}) : {1'b0, s};
    return t[CoeffW:1];
  endfunction

endpackage

// File: rtl/pe_lane.sv
// One butterfly lane: operand capture, modular multiply, then add/sub, all gated by en_i.
module pe_lane
  import poly_arith_pkg::*;
#(
  parameter int unsigned Q = 3329
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en_i,
  input  coeff_t   a_i,
  input  coeff_t   b_i,
  input  coeff_t   m_i,
  input  pe_mode_e mode_i,
  output coeff_t   u_o,
  output coeff_t   v_o
);

  localparam coeff_t QC = coeff_t'(Q);

  pe_s1_t s1_q, s1_d;
  pe_s2_t s2_q, s2_d;
  coeff_t u_q, u_d, v_q, v_d;
  coeff_t p_in;

  always_comb begin
    s1_d = s1_q;
    if (en_i) s1_d = '{mode: mode_i, a: a_i, b: b_i, m: m_i};
  end

  // INTT multiplies the difference; every other mode multiplies b.
  always_comb begin
    p_in = (s1_q.mode == ModeIntt) ? sub_mod(s1_q.a, s1_q.b, QC) : s1_q.b;
    s2_d = s2_q;
    if (en_i) begin
      s2_d.mode = s1_q.mode;
      s2_d.a    = s1_q.a;
      s2_d.b    = s1_q.b;
      s2_d.prod = mul_mod(p_in, s1_q.m, QC);
      s2_d.half = half_mod(s1_q.a, s1_q.b, QC);
    end
  end

  always_comb begin
    u_d = u_q;
    v_d = v_q;
    if (en_i) begin
      case (s2_q.mode)
        ModeNtt, ModeCwm: begin
          u_d = add_mod(s2_q.a, s2_q.prod, QC);
          v_d = sub_mod(s2_q.a, s2_q.prod, QC);
        end
        ModeIntt: begin
          u_d = s2_q.half;
          v_d = s2_q.prod;
        end
        ModeAddSub: begin
          u_d = add_mod(s2_q.a, s2_q.b, QC);
          v_d = sub_mod(s2_q.a, s2_q.b, QC);
        end
        default: begin
          u_d = s2_q.a;
          v_d = s2_q.prod;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      u_q  <= '0;
      v_q  <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      u_q  <= u_d;
      v_q  <= v_d;
    end
  end

  assign u_o = u_q;
  assign v_o = v_q;

endmodule

// File: rtl/pe_bfly_array.sv
// LANES-wide butterfly PE array with mode-tracking FSM and occupancy counter.
// Define PE_ARRAY_SKID_EN to add a 2-entry output skid that decouples in_ready_o from out_ready_i.
module pe_bfly_array
  import poly_arith_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned Q     = 3329
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  coeff_t [LANES-1:0]   a_i,
  input  coeff_t [LANES-1:0]   b_i,
  input  coeff_t [LANES-1:0]   w_i,
  input  coeff_t               tf_i,
  input  pe_mode_e             ctrl_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output coeff_t [LANES-1:0]   u_o,
  output coeff_t [LANES-1:0]   v_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 busy_o
);

  pe_state_e          state_q, state_d;
  pe_mode_e           mode_q, mode_d;
  logic [2:0]         vld_q, vld_d;
  logic [2:0]         occ_q, occ_d;
  logic               rst_done_q, rst_done_d;
  logic               adv, in_fire, out_fire;
  coeff_t [LANES-1:0] lane_u, lane_v;

  for (genvar k = 0; k < int'(LANES); k++) begin : g_lane
    pe_lane #(
      .Q(Q)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (adv),
      .a_i   (a_i[k]),
      .b_i   (b_i[k]),
      .m_i   (ctrl_i[1] ? tf_i : w_i[k]),
      .mode_i(ctrl_i),
      .u_o   (lane_u[k]),
      .v_o   (lane_v[k])
    );
  end

`ifdef PE_ARRAY_SKID_EN
  typedef struct packed {
    coeff_t [LANES-1:0] u;
    coeff_t [LANES-1:0] v;
  } res_t;

  res_t       sk0_q, sk0_d, sk1_q, sk1_d, s3;
  logic [1:0] sk_cnt_q, sk_cnt_d;
  logic       sk_push, sk_pop;

  assign s3          = res_t'({lane_u, lane_v});
  assign adv         = (sk_cnt_q != 2'd2);
  assign out_valid_o = (sk_cnt_q != 2'd0) || vld_q[2];
  assign sk_pop      = out_ready_i && (sk_cnt_q != 2'd0);
  // Stage 3 bypasses the skid only when it is empty and downstream takes the beat.
  assign sk_push     = adv && vld_q[2] && !(out_ready_i && (sk_cnt_q == 2'd0));
  assign u_o         = (sk_cnt_q != 2'd0) ? sk0_q.u : lane_u;
  assign v_o         = (sk_cnt_q != 2'd0) ? sk0_q.v : lane_v;

  always_comb begin
    sk0_d    = sk0_q;
    sk1_d    = sk1_q;
    sk_cnt_d = sk_cnt_q;
    if (sk_pop) begin
      sk0_d    = sk1_q;
      sk_cnt_d = sk_cnt_q - 2'd1;
    end
    if (sk_push) begin
      if (sk_cnt_d == 2'd0) sk0_d = s3;
      else                  sk1_d = s3;
      sk_cnt_d = sk_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk0_q    <= '0;
      sk1_q    <= '0;
      sk_cnt_q <= 2'd0;
    end else begin
      sk0_q    <= sk0_d;
      sk1_q    <= sk1_d;
      sk_cnt_q <= sk_cnt_d;
    end
  end
`else
  assign adv         = !vld_q[2] || out_ready_i;
  assign out_valid_o = vld_q[2];
  assign u_o         = lane_u;
  assign v_o         = lane_v;
`endif

  assign in_ready_o = rst_done_q &&
                      ((state_q == StIdle) ||
                       ((state_q == StRun) && adv && (ctrl_i == mode_q)));
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_fire   = out_valid_o && out_ready_i;
  assign busy_o     = (occ_q != 3'd0);

  always_comb begin
    rst_done_d = 1'b1;
    vld_d      = adv ? {vld_q[1:0], in_fire} : vld_q;
    occ_d      = occ_q;
    if (in_fire && !out_fire)      occ_d = occ_q + 3'd1;
    else if (!in_fire && out_fire) occ_d = occ_q - 3'd1;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle: begin
        if (in_fire) begin
          mode_d  = ctrl_i;
          state_d = StRun;
        end
      end
      StRun: begin
        if (occ_d == 3'd0)                          state_d = StIdle;
        else if (in_valid_i && (ctrl_i != mode_q)) state_d = StDrain;
      end
      StDrain: begin
        if (occ_d == 3'd0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mode_q     <= ModeCwm;
      vld_q      <= 3'd0;
      occ_q      <= 3'd0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      vld_q      <= vld_d;
      occ_q      <= occ_d;
      rst_done_q <= rst_done_d;
    end
  end

endmodule

// File: tb/tb_pe_bfly_array.sv
// Self-checking bench for pe_bfly_array: vector table, scoreboard and stall/drain/reset sequences.
module tb_pe_bfly_array;
  import poly_arith_pkg::*;

  localparam int unsigned LANES = 4;
  localparam int          QM    = 3329;

  typedef coeff_t [LANES-1:0] vec_t;
  typedef struct { vec_t u; vec_t v; } res_t;
  typedef struct {
    pe_mode_e mode;
    int a; int b; int w; int tf; int eu; int ev;
  } vec_rec_t;

  logic     clk, rst_n;
  vec_t     a_i, b_i, w_i, u_o, v_o;
  coeff_t   tf_i;
  pe_mode_e ctrl_i;
  logic     in_valid_i, in_ready_o, out_valid_o, out_ready_i, busy_o;

  int       checks, errors, n_out, n0, lat, n;
  logic     got, saw_stall, have;
  vec_t     held;
  res_t     sb[$];
  vec_rec_t tbl[8];

  pe_bfly_array #(.LANES(LANES), .Q(QM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_i        (a_i),
    .b_i        (b_i),
    .w_i        (w_i),
    .tf_i       (tf_i),
    .ctrl_i     (ctrl_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .u_o        (u_o),
    .v_o        (v_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .busy_o     (busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t splat(input int x);
    vec_t r;
    for (int k = 0; k < int'(LANES); k++) r[k] = coeff_t'(x);
    return r;
  endfunction

  function automatic void model(input pe_mode_e m, input int a, input int b, input int w,
                                input int tf, output int u, output int v);
    int t;
    case (m)
      ModeNtt:    begin t = (b * tf) % QM; u = (a + t) % QM; v = (a - t + QM) % QM; end
      ModeCwm:    begin t = (b * w) % QM;  u = (a + t) % QM; v = (a - t + QM) % QM; end
      ModeIntt:   begin u = ((a + b) * ((QM + 1) / 2)) % QM; v = (((a - b + QM) % QM) * tf) % QM; end
      ModeAddSub: begin u = (a + b) % QM; v = (a - b + QM) % QM; end
      default:    begin u = a; v = (b * w) % QM; end
    endcase
  endfunction

  task automatic send(input pe_mode_e m, input vec_t a, input vec_t b, input vec_t w,
                      input coeff_t tf, input res_t e);
    int k = 0;
    ctrl_i = m; a_i = a; b_i = b; w_i = w; tf_i = tf; in_valid_i = 1'b1;
    @(negedge clk);
    while (!in_ready_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("send_accepted", 64'(in_ready_o), 64'(1));
    if (in_ready_o) sb.push_back(e);
    @(posedge clk);
    #1 in_valid_i = 1'b0;
  endtask

  task automatic send_model(input pe_mode_e m, input vec_t a, input vec_t b, input vec_t w,
                            input coeff_t tf);
    res_t e;
    int   u, v;
    for (int k = 0; k < int'(LANES); k++) begin
      model(m, int'(a[k]), int'(b[k]), int'(w[k]), int'(tf), u, v);
      e.u[k] = coeff_t'(u);
      e.v[k] = coeff_t'(v);
    end
    send(m, a, b, w, tf, e);
  endtask

  task automatic wait_idle();
    int k = 0;
    @(posedge clk);
    #1;
    while ((busy_o || out_valid_o) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("idle_reached", 64'(busy_o), 64'(0));
  endtask

  task automatic monitor();
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid_o && out_ready_i) begin
        n_out++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ghost_output: got u=%h expected no output", u_o);
        end else begin
          e = sb.pop_front();
          check("result_u", 64'(u_o), 64'(e.u));
          check("result_v", 64'(v_o), 64'(e.v));
        end
      end
    end
  endtask

  initial begin
    vec_t ra, rb, rw;
    res_t e;
    checks = 0; errors = 0; n_out = 0;
    rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    a_i = '0; b_i = '0; w_i = '0; tf_i = '0; ctrl_i = ModeNtt;

    tbl[0] = '{ModeNtt,    10,   2,    999, 5,    20,   0};
    tbl[1] = '{ModeIntt,   1,    0,    0,   1,    1665, 1};
    tbl[2] = '{ModeIntt,   0,    1,    0,   1,    1665, 3328};
    tbl[3] = '{ModeCwm,    100,  50,   4,   999,  300,  3229};
    tbl[4] = '{ModeAddSub, 1000, 2000, 0,   0,    3000, 2329};
    tbl[5] = '{ModeComp,   7,    3,    10,  77,   7,    30};
    tbl[6] = '{ModeNtt,    3328, 3328, 0,   3328, 0,    3327};
    tbl[7] = '{ModeAddSub, 3328, 1,    0,   0,    0,    3327};

    #3;
    check("reset_out_valid", 64'(out_valid_o), 64'(0));
    check("reset_busy", 64'(busy_o), 64'(0));
    check("reset_in_ready", 64'(in_ready_o), 64'(0));
    check("reset_u", 64'(u_o), 64'(0));
    #19 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", 64'(in_ready_o), 64'(1));
    fork
      monitor();
    join_none

    // Unstalled latency of a single NTT beat.
    @(posedge clk);
    #1;
    ctrl_i = ModeNtt; a_i = splat(10); b_i = splat(2); w_i = splat(999); tf_i = 12'd5;
    in_valid_i = 1'b1;
    @(negedge clk);
    check("lat_ready", 64'(in_ready_o), 64'(1));
    e.u = splat(20); e.v = splat(0);
    sb.push_back(e);
    lat = 0; got = 1'b0;
    while (!got && lat < 10) begin
      @(posedge clk);
      lat++;
      #1 in_valid_i = 1'b0;
      @(negedge clk);
      got = out_valid_o;
    end
    check("latency", 64'(lat), 64'(3));
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      e.u = splat(tbl[i].eu);
      e.v = splat(tbl[i].ev);
      send(tbl[i].mode, splat(tbl[i].a), splat(tbl[i].b), splat(tbl[i].w),
           coeff_t'(tbl[i].tf), e);
    end
    wait_idle();
    check("table_drained", 64'(sb.size()), 64'(0));

    // Six NTT beats against a 5-cycle output stall.
    out_ready_i = 1'b0; n0 = n_out; saw_stall = 1'b0; have = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          for (int k = 0; k < int'(LANES); k++) begin
            ra[k] = coeff_t'((i * 397 + k * 31) % QM);
            rb[k] = coeff_t'((i * 1201 + k * 7 + 5) % QM);
            rw[k] = coeff_t'(k);
          end
          send_model(ModeNtt, ra, rb, rw, coeff_t'(17 + i));
        end
      end
      begin
        repeat (5) begin
          @(negedge clk);
          if (in_valid_i && !in_ready_o) saw_stall = 1'b1;
          if (out_valid_o) begin
            if (have) check("hold_stable", 64'(u_o), 64'(held));
            held = u_o;
            have = 1'b1;
          end
        end
        @(posedge clk);
        #1 out_ready_i = 1'b1;
      end
    join
    check("stall_ready_low", 64'(saw_stall), 64'(1));
    wait_idle();
    check("stream_count", 64'(n_out - n0), 64'(6));
    check("stream_sb_empty", 64'(sb.size()), 64'(0));

    // Mode change forces a drain before the new mode is accepted.
    e.u = splat(20); e.v = splat(0);
    send(ModeNtt, splat(10), splat(2), splat(999), 12'd5, e);
    ctrl_i = ModeAddSub; a_i = splat(1000); b_i = splat(2000); in_valid_i = 1'b1;
    @(negedge clk);
    check("drain_ready_low", 64'(in_ready_o), 64'(0));
    n = 0;
    while (!in_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_ntt_done", 64'(sb.size()), 64'(0));
    check("addsub_accepted", 64'(in_ready_o), 64'(1));
    e.u = splat(3000); e.v = splat(2329);
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid_i = 1'b0;
    wait_idle();

    // Reset with two beats in flight.
    send_model(ModeNtt, splat(5), splat(6), splat(0), 12'd7);
    send_model(ModeNtt, splat(8), splat(9), splat(0), 12'd11);
    check("busy_before_reset", 64'(busy_o), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_in_ready", 64'(in_ready_o), 64'(0));
    check("rst_u", 64'(u_o), 64'(0));
    check("rst_v", 64'(v_o), 64'(0));
    sb.delete();
    n0 = n_out;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_ghost_after_reset", 64'(n_out - n0), 64'(0));

    // Random CWM burst under random backpressure.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          for (int k = 0; k < int'(LANES); k++) begin
            ra[k] = coeff_t'($urandom_range(0, QM - 1));
            rb[k] = coeff_t'($urandom_range(0, QM - 1));
            rw[k] = coeff_t'($urandom_range(0, QM - 1));
          end
          send_model(ModeCwm, ra, rb, rw, coeff_t'($urandom_range(0, QM - 1)));
        end
      end
      begin
        repeat (40) begin
          @(posedge clk);
          #1 out_ready_i = 1'($urandom_range(0, 1));
        end
        out_ready_i = 1'b1;
      end
    join
    wait_idle();
    check("random_count", 64'(n_out - n0), 64'(16));
    check("random_sb_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
